// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N valid/ready producers.
// Optional FIFO_ARB_STATS_EN adds saturating xfer_count/stall_count outputs.
module fifo_rr_wr_arbiter #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int BURST = 4,
    localparam int GW   = $clog2(N),
    localparam int CW   = $clog2(BURST) + 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    input  logic           fifo_full,
    output logic           fifo_w_en,
    output logic [W-1:0]   fifo_data,
`ifdef FIFO_ARB_STATS_EN
    output logic [15:0]    xfer_count,
    output logic [15:0]    stall_count,
`endif
    output logic [GW-1:0]  grant_id,
    output logic           busy
);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t        state, state_n;
    logic [GW-1:0] gid_n;
    logic [GW-1:0] last_grant, last_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [GW-1:0] win;
    logic          found;
    logic          xfer;
    int            idx;

    // Next requester after last_grant, searching upward with wrap.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!found && req_valid[GW'(idx)]) begin
                found = 1'b1;
                win   = GW'(idx);
            end
        end
    end

    // State, owner, burst count and rotation pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            grant_id   <= '0;
            cnt        <= '0;
            last_grant <= GW'(N - 1);
        end else begin
            state      <= state_n;
            grant_id   <= gid_n;
            cnt        <= cnt_n;
            last_grant <= last_n;
        end
    end

    // Grant decisions and owner-side handshake / FIFO write.
    always_comb begin
        state_n   = state;
        gid_n     = grant_id;
        cnt_n     = cnt;
        last_n    = last_grant;
        req_ready = '0;
        fifo_w_en = 1'b0;
        fifo_data = '0;
        busy      = 1'b0;
        xfer      = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_n = OWN;
                    gid_n   = win;
                    cnt_n   = '0;
                end
            end
            OWN: begin
                busy                = 1'b1;
                req_ready[grant_id] = !fifo_full;
                xfer      = req_valid[grant_id] & !fifo_full;
                fifo_w_en = xfer;
                if (xfer) begin
                    fifo_data = req_data[grant_id*W +: W];
                    cnt_n     = cnt + CW'(1);
                end
                if (!req_valid[grant_id] ||
                    (xfer && cnt == CW'(BURST - 1))) begin
                    state_n = IDLE;
                    last_n  = grant_id;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef FIFO_ARB_STATS_EN
    // Saturating counters of writes and full-blocked owner cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xfer_count  <= '0;
            stall_count <= '0;
        end else begin
            if (fifo_w_en && xfer_count != 16'hFFFF)
                xfer_count <= xfer_count + 16'd1;
            if (busy && req_valid[grant_id] && fifo_full &&
                stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Self-checking bench for fifo_rr_wr_arbiter: directed table, corner
// sequences and randomized traffic against a transaction-level model.
module tb_fifo_rr_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int BURST = 4;

    logic           clk;
    logic           rstn;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_w_en;
    logic [W-1:0]   fifo_data;
    logic [1:0]     grant_id;
    logic           busy;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0]    xfer_count;
    logic [15:0]    stall_count;
`endif

    fifo_rr_wr_arbiter #(.N(N), .W(W), .BURST(BURST)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_w_en  (fifo_w_en),
        .fifo_data  (fifo_data),
`ifdef FIFO_ARB_STATS_EN
        .xfer_count (xfer_count),
        .stall_count(stall_count),
`endif
        .grant_id   (grant_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // model state: owner (-1 = nobody), words written this grant, last owner
    int m_owner;
    int m_used;
    int m_last;
    int m_xfer;
    int m_stall;

    // values sampled in the most recent step
    logic         s_busy;
    logic [1:0]   s_gid;
    logic [N-1:0] s_ready;
    logic         s_wen;
    logic [W-1:0] s_data;

    typedef struct {
        logic [3:0]  v;
        logic        f;
        logic [31:0] d;
        logic        busy;
        logic [1:0]  gid;
        logic [3:0]  rdy;
        logic        wen;
        logic [7:0]  dout;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic vbit(input logic [N-1:0] v, input int i);
        logic r;
        r = 1'b0;
        for (int j = 0; j < N; j++)
            if (j == i) r = v[j];
        return r;
    endfunction

    // lowest valid index above last, otherwise lowest valid overall
    function automatic int pick(input logic [N-1:0] v, input int last);
        int first;
        int after;
        first = -1;
        after = -1;
        for (int i = 0; i < N; i++) begin
            if (vbit(v, i)) begin
                if (first < 0) first = i;
                if (i > last && after < 0) after = i;
            end
        end
        return (after >= 0) ? after : first;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_used  = 0;
        m_last  = N - 1;
        m_xfer  = 0;
        m_stall = 0;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = '0;
        fifo_full = 1'b0;
        req_data  = '0;
        #2;
        rstn = 1'b1;
        model_reset();
    endtask

    // One clock: drive, sample at negedge, compare with model, advance.
    task automatic step(input logic [N-1:0] v, input logic f,
                        input logic [N*W-1:0] d);
        logic         e_busy;
        logic [N-1:0] e_ready;
        logic         e_wen;
        logic [W-1:0] e_data;
        logic         ov;
        req_valid = v;
        fifo_full = f;
        req_data  = d;
        @(negedge clk);
        s_busy  = busy;
        s_gid   = grant_id;
        s_ready = req_ready;
        s_wen   = fifo_w_en;
        s_data  = fifo_data;
        e_busy  = (m_owner >= 0);
        e_ready = '0;
        e_wen   = 1'b0;
        e_data  = '0;
        ov      = 1'b0;
        if (m_owner >= 0) begin
            ov = vbit(v, m_owner);
            for (int i = 0; i < N; i++)
                if (i == m_owner) e_ready[i] = !f;
            e_wen = ov && !f;
            if (e_wen) e_data = W'(d >> (m_owner * W));
        end
        chk("busy", 32'(s_busy), 32'(e_busy));
        chk("req_ready", 32'(s_ready), 32'(e_ready));
        chk("fifo_w_en", 32'(s_wen), 32'(e_wen));
        chk("fifo_data", 32'(s_data), 32'(e_data));
        chk("ready_onehot0", 32'($onehot0(s_ready)), 32'd1);
        if (m_owner >= 0)
            chk("grant_id", 32'(s_gid), 32'(m_owner));
`ifdef FIFO_ARB_STATS_EN
        chk("xfer_count", 32'(xfer_count), 32'(m_xfer));
        chk("stall_count", 32'(stall_count), 32'(m_stall));
`endif
        if (m_owner < 0) begin
            if (|v) begin
                m_owner = pick(v, m_last);
                m_used  = 0;
            end
        end else begin
            if (e_wen) begin
                m_used++;
                if (m_xfer < 16'hFFFF) m_xfer++;
            end
            if (ov && f && m_stall < 16'hFFFF) m_stall++;
            if (!ov || (e_wen && m_used == BURST)) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gq[$];
        int wc[$];
        int nw;
        logic pb;
        logic [N-1:0] rv;

        n_chk  = 0;
        n_fail = 0;
        rstn      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // reset state
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_wen", 32'(fifo_w_en), 32'd0);
        chk("rst_data", 32'(fifo_data), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        @(posedge clk);
        #1;

        // single producer 2 streaming A0..A5
        tbl[0] = '{4'b0100, 1'b0, 32'h00A0_0000, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        tbl[1] = '{4'b0100, 1'b0, 32'h00A0_0000, 1'b1, 2'd2, 4'b0100, 1'b1, 8'hA0};
        tbl[2] = '{4'b0100, 1'b0, 32'h00A1_0000, 1'b1, 2'd2, 4'b0100, 1'b1, 8'hA1};
        tbl[3] = '{4'b0100, 1'b0, 32'h00A2_0000, 1'b1, 2'd2, 4'b0100, 1'b1, 8'hA2};
        tbl[4] = '{4'b0100, 1'b0, 32'h00A3_0000, 1'b1, 2'd2, 4'b0100, 1'b1, 8'hA3};
        tbl[5] = '{4'b0100, 1'b0, 32'h00A4_0000, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        tbl[6] = '{4'b0100, 1'b0, 32'h00A4_0000, 1'b1, 2'd2, 4'b0100, 1'b1, 8'hA4};
        tbl[7] = '{4'b0100, 1'b0, 32'h00A5_0000, 1'b1, 2'd2, 4'b0100, 1'b1, 8'hA5};
        tbl[8] = '{4'b0000, 1'b0, 32'h0000_0000, 1'b1, 2'd2, 4'b0100, 1'b0, 8'h00};
        tbl[9] = '{4'b0000, 1'b0, 32'h0000_0000, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].f, tbl[i].d);
            chk("tbl_busy", 32'(s_busy), 32'(tbl[i].busy));
            chk("tbl_ready", 32'(s_ready), 32'(tbl[i].rdy));
            chk("tbl_wen", 32'(s_wen), 32'(tbl[i].wen));
            chk("tbl_data", 32'(s_data), 32'(tbl[i].dout));
            if (tbl[i].busy)
                chk("tbl_gid", 32'(s_gid), 32'(tbl[i].gid));
        end

        // all four valid: rotation 0,1,2,3,0 with 4 writes each
        do_reset();
        pb = 1'b0;
        for (int c = 0; c < 25; c++) begin
            step(4'b1111, 1'b0, $urandom);
            if (s_busy && !pb) begin
                gq.push_back(int'(s_gid));
                wc.push_back(0);
            end
            if (s_wen && wc.size() > 0) wc[$] = wc[$] + 1;
            pb = s_busy;
        end
        chk("rot_grants", 32'(gq.size()), 32'd5);
        for (int i = 0; i < gq.size(); i++) begin
            chk("rot_order", 32'(gq[i]), 32'(i % N));
            chk("rot_words", 32'(wc[i]), 32'(BURST));
        end

        // owner 1 stalled by full for 3 cycles after 2 words
        do_reset();
        nw = 0;
        step(4'b0010, 1'b0, 32'h0000_1100);
        for (int c = 0; c < 2; c++) begin
            step(4'b0010, 1'b0, 32'(16'h1200 + c * 256));
            nw += int'(s_wen);
        end
        for (int c = 0; c < 3; c++) begin
            step(4'b0010, 1'b1, 32'h0000_EE00);
            chk("full_busy", 32'(s_busy), 32'd1);
            chk("full_gid", 32'(s_gid), 32'd1);
            chk("full_ready", 32'(s_ready), 32'd0);
            chk("full_wen", 32'(s_wen), 32'd0);
        end
        for (int c = 0; c < 2; c++) begin
            step(4'b0010, 1'b0, 32'(16'h1400 + c * 256));
            nw += int'(s_wen);
        end
        chk("full_words", 32'(nw), 32'd4);
        step(4'b0010, 1'b0, 32'h0000_1600);
        chk("full_idle", 32'(s_busy), 32'd0);
`ifdef FIFO_ARB_STATS_EN
        chk("stall_3", 32'(stall_count), 32'd3);
        chk("xfer_4", 32'(xfer_count), 32'd4);
`endif

        // owner 3 drops after one word while 0 waits
        do_reset();
        step(4'b1000, 1'b0, 32'h3300_0000);
        step(4'b1001, 1'b0, 32'h3400_0001);
        chk("drop_gid3", 32'(s_gid), 32'd3);
        chk("drop_wen", 32'(s_wen), 32'd1);
        chk("drop_data", 32'(s_data), 32'h34);
        step(4'b0001, 1'b0, 32'h0000_0002);
        chk("drop_nowrite", 32'(s_wen), 32'd0);
        step(4'b0001, 1'b0, 32'h0000_0003);
        chk("drop_idle", 32'(s_busy), 32'd0);
        step(4'b0001, 1'b0, 32'h0000_0004);
        chk("drop_gid0", 32'(s_gid), 32'd0);
        chk("drop_busy", 32'(s_busy), 32'd1);

        // asynchronous reset mid-burst
        do_reset();
        step(4'b1111, 1'b0, 32'h4433_2211);
        step(4'b1111, 1'b0, 32'h4433_2211);
        step(4'b1111, 1'b0, 32'h4433_2211);
        chk("arst_pre_busy", 32'(s_busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        chk("arst_wen", 32'(fifo_w_en), 32'd0);
        chk("arst_data", 32'(fifo_data), 32'd0);
        #1;
        rstn = 1'b1;
        model_reset();
        step(4'b1111, 1'b0, 32'h4433_2211);
        chk("arst_idle", 32'(s_busy), 32'd0);
        step(4'b1111, 1'b0, 32'h4433_2211);
        chk("arst_gid0", 32'(s_gid), 32'd0);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            rv = N'($urandom);
            if ($urandom_range(0, 3) != 0) rv = rv | (N'(1) << $urandom_range(0, N - 1));
            step(rv, ($urandom_range(0, 3) == 0), $urandom);
        end

`ifdef FIFO_ARB_STATS_EN
        // drive past 65535 writes to reach saturation
        do_reset();
        while (m_xfer < 16'hFFFF) step(4'b0001, 1'b0, $urandom);
        for (int c = 0; c < 5000; c++) step(4'b0001, 1'b0, $urandom);
        chk("xfer_sat", 32'(xfer_count), 32'h0000_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
